sha256_core_arbiter: RTL
========================

// Module: sha256_core_arbiter
// PURPOSE
//  Shares one sha256_block compression core among NREQ requesters (nonce workers, message scheduler).
//  Round-robin grant; latches the winner's h_init/block for the whole compression, pulses core_start,
//  waits for core_done, returns the 256-bit hash with a one-cycle ack to the winner.
//  A watchdog aborts a hung compression.
//  Sits between requesters and the single core instance in the bitcoin_hash top.
// PARAMETERS
//  NREQ     4    number of requesters (2..16)
//  IDW      2    requester id width, $clog2(NREQ)
//  TIMEOUT  255  WAIT cycles before abort; must exceed core latency (~66)
// PORTS
//  clk          in   1          clock; all logic on posedge
//  reset        in   1          synchronous, active-high reset
//  req          in   NREQ       req[i]=1: requester i has a block pending
//  req_h_init   in   NREQ*256   slice i = [i*256 +: 256]; word0 in MSBs
//  req_block    in   NREQ*512   slice i = [i*512 +: 512]; word0 in MSBs
//  ack          out  NREQ       one-cycle pulse to the served requester
//  rsp_hash     out  256        result, word0 in MSBs; valid while ack!=0
//  rsp_err      out  1          1 with ack: timed out, rsp_hash = 0
//  rsp_id       out  IDW        id of the served requester; valid with ack
//  busy         out  1          1 in any state other than IDLE
//  core_start   out  1          start pulse to the core
//  core_h_init  out  256        latched h_init of the granted requester
//  core_block   out  512        latched block; held stable until RESP
//  core_hash    in   256        core result, word0 in MSBs
//  core_done    in   1          one-cycle completion pulse from the core
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, wdog=0, ack=0, rsp_hash=0, rsp_err=0, rsp_id=0, busy=0,
//   core_start=0, core_h_init=0, core_block=0. Same in every state (reset mid-op aborts, no ack).
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE: req sampled only here. If req!=0, pick the first set bit scanning rr_ptr, rr_ptr+1, ...
//   (mod NREQ). Latch id, req_h_init slice and req_block slice into core_h_init/core_block. Go ISSUE.
//   If req==0, stay.
//  ISSUE: core_start=1 for exactly this cycle; wdog<=0; go WAIT.
//  WAIT: core_start=0; wdog increments each cycle.
//   core_done=1 -> rsp_hash<=core_hash, rsp_err<=0, go RESP.
//   Else wdog==TIMEOUT-1 -> rsp_hash<=0, rsp_err<=1, go RESP.
//   core_done in the timeout cycle wins, giving a normal completion.
//  RESP: ack[id]=1, rsp_id=id for one cycle; rr_ptr<=(id+1)%NREQ (wraps NREQ-1 -> 0); go IDLE.
//  core_done outside WAIT (stale after a timeout) is ignored.
//  Requester rule: hold req and its data until ack. Drop req on the edge that samples ack=1.
//   req still high in the following IDLE cycle is a new request.
//   The slice is latched at grant, so later changes to it do not affect the compression in flight.
//  Deasserting req before ack does not cancel: the ack still issues.
//  Latency: req rising with the arbiter idle -> core_start 1 cycle later.
//   ack = 2 cycles after core_done (capture, then RESP). Min back-to-back spacing: ack->core_start 2 cycles.
//  Fairness: with all req held high, grants go 0,1,..,NREQ-1,0,...; no requester waits more than NREQ-1 services.
//  Only one core_start is ever outstanding.
//  Outputs are registered except ack/rsp_id/busy/core_start, which are decoded from registered state.
// TESTING
//  1. req=0001, h_init=SHA-256 IV, block=61626380_0..0_00000018 ("abc"), real core ->
//     ack[0] pulse, rsp_err=0, rsp_hash=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
//  2. req=1010 at once, rr_ptr=0 -> grant 1 then 3.
//     Two acks, rsp_id 1 then 3, each hash correct for its own block.
//  3. req=1111 held for 8 services -> rsp_id sequence 0,1,2,3,0,1,2,3; exactly one core_start per ack.
//  4. Stub core never asserts done -> core_done absent; ack at TIMEOUT+2 cycles after core_start
//     with rsp_err=1, rsp_hash=0; next request still served.
//     Then a stub core_done in IDLE -> no ack, no state change.
//  5. reset=1 in WAIT -> next cycle all outputs 0, state IDLE.
//     After release, req=0100 -> served with rsp_id=2 (rr_ptr restarted at 0).
//  6. Change req_block of the granted requester during WAIT -> core_block unchanged; hash matches the original block.

Source files
------------

// File: rtl/sha256_core_arbiter_if.sv
// Requester- and core-facing bundle of the SHA-256 core arbiter.
// The arbiter takes the slave view; the requesters/core side takes the master view.
interface sha256_core_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]     req;
    logic [NREQ*256-1:0] req_h_init;
    logic [NREQ*512-1:0] req_block;
    logic [NREQ-1:0]     ack;
    logic [255:0]        rsp_hash;
    logic                rsp_err;
    logic [IDW-1:0]      rsp_id;
    logic                busy;
    logic                core_start;
    logic [255:0]        core_h_init;
    logic [511:0]        core_block;
    logic [255:0]        core_hash;
    logic                core_done;

    modport master (
        output req, req_h_init, req_block, core_hash, core_done,
        input  ack, rsp_hash, rsp_err, rsp_id, busy, core_start, core_h_init, core_block
    );

    modport slave (
        input  req, req_h_init, req_block, core_hash, core_done,
        output ack, rsp_hash, rsp_err, rsp_id, busy, core_start, core_h_init, core_block
    );
endinterface

// File: rtl/sha256_core_arbiter.sv
// Round-robin arbiter sharing one SHA-256 compression core among NREQ requesters.
// core_done/core_hash are captured one cycle before use; the watchdog decision is aligned to that stage.
module sha256_core_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 255
) (
    input logic                  clk,
    input logic                  reset,
    sha256_core_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int             WDW       = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);
    localparam logic [IDW-1:0] ID_LAST   = IDW'(NREQ - 1);
    localparam logic [IDW:0]   NREQ_W    = (IDW+1)'(NREQ);

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           tmo_q, tmo_d;
    logic           done_q, done_d;
    logic [255:0]   hash_q, hash_d;
    logic [255:0]   rsp_hash_q, rsp_hash_d;
    logic           rsp_err_q, rsp_err_d;
    logic [255:0]   core_h_init_q, core_h_init_d;
    logic [511:0]   core_block_q, core_block_d;

    logic           grant_vld_s;
    logic [IDW-1:0] grant_id_s;
    logic [IDW:0]   scan_raw_s;
    logic [IDW:0]   scan_idx_s;

    // Round-robin scan starting at rr_ptr, first requester found wins
    always_comb begin
        grant_vld_s = 1'b0;
        grant_id_s  = '0;
        scan_raw_s  = '0;
        scan_idx_s  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_raw_s  = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            scan_idx_s  = (scan_raw_s >= NREQ_W) ? (scan_raw_s - NREQ_W) : scan_raw_s;
            grant_id_s  = (bus.req[scan_idx_s[IDW-1:0]] && !grant_vld_s) ? scan_idx_s[IDW-1:0] : grant_id_s;
            grant_vld_s = grant_vld_s | bus.req[scan_idx_s[IDW-1:0]];
        end
    end

    // Next-state and next-output computation for the arbitration FSM
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        id_d          = id_q;
        wdog_d        = wdog_q;
        rsp_hash_d    = rsp_hash_q;
        rsp_err_d     = rsp_err_q;
        core_h_init_d = core_h_init_q;
        core_block_d  = core_block_q;
        // A done outside WAIT is stale (e.g. after an abort) and must not be seen later
        done_d        = bus.core_done && (state_q == WAIT);
        hash_d        = bus.core_done ? bus.core_hash : hash_q;
        tmo_d         = (state_q == WAIT) && (wdog_q == WDOG_LAST);

        case (state_q)
            IDLE: begin
                if (grant_vld_s) begin
                    id_d          = grant_id_s;
                    core_h_init_d = bus.req_h_init[int'(grant_id_s)*256 +: 256];
                    core_block_d  = bus.req_block[int'(grant_id_s)*512 +: 512];
                    state_d       = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wdog_d = wdog_q + WDW'(1);
                if (done_q) begin
                    rsp_hash_d = hash_q;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (tmo_q) begin
                    rsp_hash_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                rr_ptr_d = (id_q == ID_LAST) ? '0 : (id_q + IDW'(1));
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            id_q          <= '0;
            wdog_q        <= '0;
            tmo_q         <= 1'b0;
            done_q        <= 1'b0;
            hash_q        <= '0;
            rsp_hash_q    <= '0;
            rsp_err_q     <= 1'b0;
            core_h_init_q <= '0;
            core_block_q  <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            id_q          <= id_d;
            wdog_q        <= wdog_d;
            tmo_q         <= tmo_d;
            done_q        <= done_d;
            hash_q        <= hash_d;
            rsp_hash_q    <= rsp_hash_d;
            rsp_err_q     <= rsp_err_d;
            core_h_init_q <= core_h_init_d;
            core_block_q  <= core_block_d;
        end
    end

    assign bus.ack         = (state_q == RESP) ? (NREQ'(1) << id_q) : '0;
    assign bus.rsp_id      = (state_q == RESP) ? id_q : '0;
    assign bus.busy        = (state_q != IDLE);
    assign bus.core_start  = (state_q == ISSUE);
    assign bus.rsp_hash    = rsp_hash_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.core_h_init = core_h_init_q;
    assign bus.core_block  = core_block_q;
endmodule
